// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch/decode register for the PC3 datapath.
//
// Fetches one 32-bit instruction at a time over a req/ack read port, holds it
// until the next stage takes it (valido & pronto), and slices it into the
// register and raw-immediate fields the decoder and sign-extender use.
// A redirect (desvio) flushes the held or in-flight instruction; a response
// that was already requested when the redirect arrived is drained and dropped.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   habilita             allow new fetches
//   desvio, endereco_desvio  one-cycle redirect pulse and its target
//   mem_req, mem_endereco    registered read request and word address
//   mem_ack, mem_dado        read response strobe and data
//   valido, pronto           output handshake for the held instruction
//   instrucao, pc_instrucao  held instruction and its address
//   opcode/rs/rt/rd          register fields of instrucao
//   imediato16/21/_s         raw immediate slices for the sign-extender
//   selecao_ext              sign-extender format select (11 when not valido)
//
// Optional build macro BUSCA_CONTADOR_EN adds contador_entregues, a wrapping
// 32-bit count of delivered instructions.

module busca_instrucao #(
  parameter int unsigned LARGURA_PC = 16,
  parameter int unsigned PC_INICIAL = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic                  desvio,
  input  logic [LARGURA_PC-1:0] endereco_desvio,
  output logic                  mem_req,
  output logic [LARGURA_PC-1:0] mem_endereco,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_dado,
  output logic                  valido,
  input  logic                  pronto,
  output logic [31:0]           instrucao,
  output logic [LARGURA_PC-1:0] pc_instrucao,
  output logic [5:0]            opcode,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [15:0]           imediato16,
  output logic [20:0]           imediato21,
  output logic [15:0]           imediato_s,
  output logic [1:0]            selecao_ext
`ifdef BUSCA_CONTADOR_EN
  ,
  output logic [31:0]           contador_entregues
`endif
);

  localparam logic [LARGURA_PC-1:0] PcReset = LARGURA_PC'(PC_INICIAL);
  localparam logic [LARGURA_PC-1:0] PcUm    = LARGURA_PC'(1);

  typedef enum logic [1:0] {
    StOcioso,
    StBusca,
    StDescarta,
    StCheio
  } estado_e;

  estado_e               state_q, state_d;
  logic [LARGURA_PC-1:0] pc_q, pc_d;
  logic                  mem_req_q, mem_req_d;
  logic [LARGURA_PC-1:0] mem_end_q, mem_end_d;
  logic                  valido_q, valido_d;
  logic [31:0]           instr_q, instr_d;
  logic [LARGURA_PC-1:0] pc_instr_q, pc_instr_d;

  // PC after this cycle's redirect, used whenever a new request is launched
  // in the same edge as the redirect.
  logic [LARGURA_PC-1:0] pc_alvo;
  assign pc_alvo = desvio ? endereco_desvio : pc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StOcioso;
      pc_q       <= PcReset;
      mem_req_q  <= 1'b0;
      mem_end_q  <= PcReset;
      valido_q   <= 1'b0;
      instr_q    <= '0;
      pc_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_end_q  <= mem_end_d;
      valido_q   <= valido_d;
      instr_q    <= instr_d;
      pc_instr_q <= pc_instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_end_d  = mem_end_q;
    valido_d   = valido_q;
    instr_d    = instr_q;
    pc_instr_d = pc_instr_q;

    unique case (state_q)
      StOcioso: begin
        if (desvio) begin
          pc_d = endereco_desvio;
        end else if (habilita) begin
          state_d   = StBusca;
          mem_req_d = 1'b1;
          mem_end_d = pc_q;
        end
      end

      StBusca: begin
        if (desvio) begin
          pc_d     = endereco_desvio;
          valido_d = 1'b0;
          if (mem_ack) begin
            // Response consumed this edge: relaunch straight at the target.
            mem_end_d = endereco_desvio;
          end else begin
            // Request must stay up at the old address until it is answered.
            state_d = StDescarta;
          end
        end else if (mem_ack) begin
          instr_d    = mem_dado;
          pc_instr_d = pc_q;
          pc_d       = pc_q + PcUm;
          valido_d   = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = StCheio;
        end
      end

      StDescarta: begin
        pc_d     = pc_alvo;
        valido_d = 1'b0;
        if (mem_ack) begin
          if (habilita) begin
            state_d   = StBusca;
            mem_req_d = 1'b1;
            mem_end_d = pc_alvo;
          end else begin
            state_d   = StOcioso;
            mem_req_d = 1'b0;
          end
        end
      end

      StCheio: begin
        if (desvio || pronto) begin
          pc_d     = pc_alvo;
          valido_d = 1'b0;
          if (habilita) begin
            state_d   = StBusca;
            mem_req_d = 1'b1;
            mem_end_d = pc_alvo;
          end else begin
            state_d = StOcioso;
          end
        end
      end

      default: state_d = StOcioso;
    endcase
  end

  assign mem_req      = mem_req_q;
  assign mem_endereco = mem_end_q;
  assign valido       = valido_q;
  assign instrucao    = instr_q;
  assign pc_instrucao = pc_instr_q;

  assign opcode     = instr_q[31:26];
  assign rs         = instr_q[25:21];
  assign rt         = instr_q[20:16];
  assign rd         = instr_q[15:11];
  assign imediato16 = instr_q[15:0];
  assign imediato21 = instr_q[20:0];
  assign imediato_s = {instr_q[25:21], instr_q[10:0]};

  // Format class from opcode[5:4]: R->11, I->00, J->01, S->10.
  always_comb begin
    selecao_ext = 2'b11;
    if (valido_q) begin
      unique case (instr_q[31:30])
        2'b00: selecao_ext = 2'b11;
        2'b01: selecao_ext = 2'b00;
        2'b10: selecao_ext = 2'b01;
        2'b11: selecao_ext = 2'b10;
        default: selecao_ext = 2'b11;
      endcase
    end
  end

`ifdef BUSCA_CONTADOR_EN
  logic [31:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (valido_q && pronto) begin
      cont_d = cont_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign contador_entregues = cont_q;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model
// (pending request / pending drop / held instruction) kept in this file.

module tb_busca_instrucao;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        habilita = 1'b0;
  logic        desvio = 1'b0;
  logic [15:0] endereco_desvio = '0;
  logic        mem_req;
  logic [15:0] mem_endereco;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_dado = '0;
  logic        valido;
  logic        pronto = 1'b0;
  logic [31:0] instrucao;
  logic [15:0] pc_instrucao;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imediato16;
  logic [20:0] imediato21;
  logic [15:0] imediato_s;
  logic [1:0]  selecao_ext;
`ifdef BUSCA_CONTADOR_EN
  logic [31:0] contador_entregues;
`endif

  busca_instrucao #(
    .LARGURA_PC(16),
    .PC_INICIAL(0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .desvio          (desvio),
    .endereco_desvio (endereco_desvio),
    .mem_req         (mem_req),
    .mem_endereco    (mem_endereco),
    .mem_ack         (mem_ack),
    .mem_dado        (mem_dado),
    .valido          (valido),
    .pronto          (pronto),
    .instrucao       (instrucao),
    .pc_instrucao    (pc_instrucao),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .imediato16      (imediato16),
    .imediato21      (imediato21),
    .imediato_s      (imediato_s),
    .selecao_ext     (selecao_ext)
`ifdef BUSCA_CONTADOR_EN
    ,
    .contador_entregues (contador_entregues)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic        m_req;      // a read is outstanding
  logic [15:0] m_addr;     // address of the outstanding read
  logic        m_discard;  // outstanding read's data must be dropped
  logic        m_valid;
  logic [31:0] m_instr;
  logic [15:0] m_pcinstr;
  logic [15:0] m_pc;
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_addr = 16'h0000; m_discard = 1'b0; m_valid = 1'b0;
    m_instr = '0; m_pcinstr = '0; m_pc = 16'h0000; m_cnt = '0;
  endtask

  task automatic model_issue();
    m_req  = 1'b1;
    m_addr = m_pc;
  endtask

  task automatic model_step(input logic h, input logic d, input logic [15:0] dt,
                            input logic a, input logic [31:0] dat, input logic p);
    logic was_discard;
    if (m_valid && p) m_cnt = m_cnt + 32'd1;
    if (m_req) begin
      if (a) begin
        was_discard = m_discard;
        m_req = 1'b0;
        m_discard = 1'b0;
        if (!was_discard && !d) begin
          m_instr   = dat;
          m_pcinstr = m_pc;
          m_pc      = m_pc + 16'd1;
          m_valid   = 1'b1;
        end else begin
          if (d) m_pc = dt;
          // Redirect on a live fetch always refetches; a drained drop waits for habilita.
          if ((d && !was_discard) || (was_discard && h)) model_issue();
        end
      end else if (d) begin
        m_pc = dt;
        m_discard = 1'b1;
      end
    end else if (m_valid) begin
      if (d || p) begin
        m_valid = 1'b0;
        if (d) m_pc = dt;
        if (h) model_issue();
      end
    end else begin
      if (d) m_pc = dt;
      else if (h) model_issue();
    end
  endtask

  task automatic check_all();
    check_eq("mem_req", mem_req, m_req);
    if (m_req) check_eq("mem_endereco", mem_endereco, m_addr);
    check_eq("valido", valido, m_valid);
    check_eq("instrucao", instrucao, m_instr);
    check_eq("pc_instrucao", pc_instrucao, m_pcinstr);
    check_eq("opcode", opcode, m_instr[31:26]);
    check_eq("rs", rs, m_instr[25:21]);
    check_eq("rt", rt, m_instr[20:16]);
    check_eq("rd", rd, m_instr[15:11]);
    check_eq("imediato16", imediato16, m_instr[15:0]);
    check_eq("imediato21", imediato21, m_instr[20:0]);
    check_eq("imediato_s", imediato_s, {m_instr[25:21], m_instr[10:0]});
    // Format select is opcode[5:4] rotated by +3 (00->11, 01->00, 10->01, 11->10).
    check_eq("selecao_ext", selecao_ext,
             m_valid ? 32'(2'(m_instr[31:30] + 2'd3)) : 32'd3);
`ifdef BUSCA_CONTADOR_EN
    check_eq("contador", contador_entregues, m_cnt);
`endif
  endtask

  task automatic step(input logic h, input logic d, input logic [15:0] dt,
                      input logic a, input logic [31:0] dat, input logic p);
    @(negedge clock);
    habilita = h; desvio = d; endereco_desvio = dt;
    mem_ack = a; mem_dado = dat; pronto = p;
    @(posedge clock);
    model_step(h, d, dt, a, dat, p);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    habilita = 1'b0; desvio = 1'b0; mem_ack = 1'b0; pronto = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("rst_mem_endereco", mem_endereco, 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic prev_d;
    logic h, d, a, p;
    model_reset();
    apply_reset();

    // First fetch with ack in the first request cycle.
    step(1, 0, 16'h0, 0, 32'h0, 0);
    check_eq("first_addr", mem_endereco, 32'h0);
    step(1, 0, 16'h0, 1, 32'h4412_8001, 0);
    check_eq("first_valido", valido, 32'h1);
    check_eq("first_opcode", opcode, 32'h11);
    check_eq("first_sel", selecao_ext, 32'h0);
    check_eq("first_imm16", imediato16, 32'h8001);

    // Held while pronto=0 and memory data churns.
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0, $urandom, 0);
    check_eq("hold_instr", instrucao, 32'h4412_8001);
    check_eq("hold_req", mem_req, 32'h0);
    step(1, 0, 16'h0, 0, 32'h0, 1);
    check_eq("accept_valido", valido, 32'h0);
    check_eq("next_req", mem_req, 32'h1);
    check_eq("next_addr", mem_endereco, 32'h1);

    // Redirect while waiting; late response is dropped.
    step(1, 1, 16'h0040, 0, 32'h0, 0);
    step(1, 0, 16'h0, 0, 32'h0, 0);
    step(1, 0, 16'h0, 0, 32'h0, 0);
    step(1, 0, 16'h0, 1, 32'hDEAD_BEEF, 0);
    check_eq("drop_valido", valido, 32'h0);
    check_eq("drop_addr", mem_endereco, 32'h40);

    // Redirect coincident with ack.
    step(1, 1, 16'h0080, 1, $urandom, 0);
    check_eq("coinc_req", mem_req, 32'h1);
    check_eq("coinc_addr", mem_endereco, 32'h80);

    // PC wrap at all-ones.
    step(1, 1, 16'hFFFF, 0, 32'h0, 0);
    step(1, 0, 16'h0, 1, $urandom, 0);
    step(1, 0, 16'h0, 1, 32'h8000_1234, 0);
    check_eq("wrap_pcinstr", pc_instrucao, 32'hFFFF);
    step(1, 0, 16'h0, 0, 32'h0, 1);
    check_eq("wrap_addr", mem_endereco, 32'h0);

    // Asynchronous reset mid-fetch and with an instruction held.
    step(1, 0, 16'h0, 0, 32'h0, 0);
    #2 reset = 1'b0;
    #1 check_eq("async_req", mem_req, 32'h0);
    model_reset();
    @(negedge clock) reset = 1'b1;
    step(1, 0, 16'h0, 0, 32'h0, 0);
    step(1, 0, 16'h0, 1, 32'h1234_5678, 0);
    #2 reset = 1'b0;
    #1 check_eq("async_valido", valido, 32'h0);
    model_reset();
    @(negedge clock) reset = 1'b1;

    // Three deliveries from reset.
    step(1, 0, 16'h0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, 1, $urandom, 0);
      step(1, 0, 16'h0, 0, 32'h0, 1);
    end
`ifdef BUSCA_CONTADOR_EN
    check_eq("cnt3", contador_entregues, 32'd3);
`endif

    // Randomized traffic.
    prev_d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      h = ($urandom_range(0, 9) < 8);
      d = !prev_d && ($urandom_range(0, 9) == 0);
      a = m_req && $urandom_range(0, 1);
      p = $urandom_range(0, 1);
      step(h, d, 16'($urandom), a, $urandom, p);
      prev_d = d;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction fetch/decode register for the PC3 datapath. Issues word reads to instruction memory through a req/ack handshake and holds the returned 32-bit instruction until the downstream stage accepts it. Splits the instruction into register and immediate fields and drives the sign-extender's three raw immediate inputs and its 2-bit format select directly. Handles redirect (branch/jump) flushes, including responses that are still in flight.

Parameters:
LARGURA_PC, 16, width of PC and memory word address
PC_INICIAL, 0, PC value loaded at reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
habilita  in  1  allow new fetches
desvio  in  1  redirect request, one-cycle pulse
endereco_desvio  in  LARGURA_PC  redirect target
mem_req  out  1  memory read request (registered)
mem_endereco  out  LARGURA_PC  word address (registered)
mem_ack  in  1  read data valid this cycle
mem_dado  in  32  read data
valido  out  1  instrucao holds an undelivered instruction
pronto  in  1  downstream accepts when valido&pronto
instrucao  out  32  held instruction
pc_instrucao  out  LARGURA_PC  address of held instruction
opcode  out  6  instrucao[31:26]
rs  out  5  instrucao[25:21]
rt  out  5  instrucao[20:16]
rd  out  5  instrucao[15:11]
imediato16  out  16  instrucao[15:0], to extender input 1
imediato21  out  21  instrucao[20:0], to extender input 2
imediato_s  out  16  {instrucao[25:21], instrucao[10:0]}, to extender input 3
selecao_ext  out  2  extender select

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO; pc=PC_INICIAL; mem_req=0; mem_endereco=PC_INICIAL; valido=0; instrucao=0; pc_instrucao=0.
- States: OCIOSO, BUSCA, DESCARTA, CHEIO.
- OCIOSO: when habilita=1, go to BUSCA with mem_req=1 and mem_endereco=pc on the next edge.
- BUSCA: mem_req and mem_endereco held stable until mem_ack. On an edge with mem_ack=1: instrucao<=mem_dado, pc_instrucao<=pc, pc<=pc+1, valido<=1, mem_req<=0, go to CHEIO. Minimum latency: ack in the first BUSCA cycle, then valido on the next edge. Deasserting habilita does not abort an outstanding request.
- CHEIO: valido=1, and instrucao is frozen. On valido&pronto: valido<=0. If habilita=1, go to BUSCA (mem_req=1 next cycle, address pc); otherwise go to OCIOSO.
- desvio has priority over everything else in every state:
  - pc<=endereco_desvio and valido<=0.
  - In BUSCA without mem_ack: go to DESCARTA. mem_req stays high at the old address until ack (the protocol forbids withdrawing a request).
  - In BUSCA with mem_ack in the same cycle: discard the data and go to BUSCA with the new address.
  - In CHEIO: drop the held instruction. If pronto was also high, the instruction counts as delivered. Go to BUSCA if habilita=1, else OCIOSO.
  - In OCIOSO: load pc only.
  - In DESCARTA: update pc again and stay in DESCARTA.
- DESCARTA: on mem_ack, discard the data and leave instrucao unchanged. Then go to BUSCA (habilita=1) or OCIOSO.
- pc increments modulo 2^LARGURA_PC, so all-ones wraps to 0.
- Field outputs are pure combinational slices of instrucao, unextended.
- selecao_ext by opcode[5:4]: 00 (R-type) gives 2'b11; 01 (I) gives 2'b00; 10 (J) gives 2'b01; 11 (S) gives 2'b10. It is forced to 2'b11 whenever valido=0.

Optional Feature:
BUSCA_CONTADOR_EN
- Defined: adds output contador_entregues (32 bits). It resets to 0, increments on every valido&pronto edge (including pronto coincident with desvio), and wraps at 2^32.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, habilita=1, ack on first BUSCA cycle with mem_dado=32'h4412_8001 → mem_endereco=0; next edge valido=1, opcode=6'h11, selecao_ext=00, imediato16=16'h8001, pc=1.
- Held instruction, pronto=0 for 5 cycles, mem_dado changing → instrucao and valido stable; mem_req=0; then pronto=1 → valido=0, mem_req=1 at address 1.
- desvio to 16'h0040 while BUSCA waits, ack 3 cycles later with 32'hDEAD_BEEF → data discarded, valido stays 0, next request at 16'h0040.
- desvio coincident with mem_ack → ack data dropped, mem_req=1 at endereco_desvio next cycle.
- pc=16'hFFFF fetch completes → pc_instrucao=16'hFFFF, next mem_endereco=0.
- Reset asserted mid-BUSCA → mem_req=0 and valido=0 immediately (asynchronous); with BUSCA_CONTADOR_EN, 3 deliveries give contador_entregues=3.
